counter_modn: RTL and testbench
===============================

Name: counter_modn

Overview:
- Parametrised modulo-N counter for the clock datapath (seconds, minutes, hours digits); the generalised successor of the fixed mod-6 digit counter.
- Counts up or down, supports synchronous preset load, and provides registered terminal flags plus a same-cycle carry for cascading stages.
- Instances chain by feeding carry of one stage into ena of the next.

Parameters:
- MODULUS, 6, number of states; counter range 0..MODULUS-1; legal range 2..256.
- WIDTH, $clog2(MODULUS), counter width in bits; must satisfy 2**WIDTH >= MODULUS.
- RESET_VAL, 0, value loaded on reset; must be < MODULUS.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- res  in  1  reset, synchronous, active-high.
- ena  in  1  count enable; one step per cycle while high.
- dir  in  1  0 = count up, 1 = count down.
- load  in  1  synchronous preset strobe.
- load_val  in  WIDTH  preset value.
- cnt  out  WIDTH  registered counter value.
- is_max  out  1  registered; high iff cnt == MODULUS-1.
- is_min  out  1  registered; high iff cnt == 0.
- carry  out  1  combinational; ena & !load & ((!dir & is_max) | (dir & is_min)).

Behaviour:
- Reset: if res is high at a clock edge, the block sets cnt = RESET_VAL, is_max = (RESET_VAL == MODULUS-1) and is_min = (RESET_VAL == 0).
- Priority per edge: res > load > ena > hold.
- Load: cnt <= load_val if load_val < MODULUS, else cnt <= MODULUS-1 (clamp). ena and dir are ignored in a load cycle, and carry is forced low.
- Count up (ena=1, dir=0): cnt <= (cnt == MODULUS-1) ? 0 : cnt+1.
- Count down (ena=1, dir=1): cnt <= (cnt == 0) ? MODULUS-1 : cnt-1.
- Hold (ena=0): cnt, is_max and is_min are unchanged.
- is_max and is_min are computed from the next value of cnt and registered with it. They are always consistent with cnt in the same cycle, with zero cycles of lag.
- carry:
  - Is purely combinational from registered flags and current inputs.
  - Is high in exactly the cycle whose edge wraps the counter.
  - A downstream stage sampling carry as its ena therefore steps on the same edge as the wrap.
- dir may change on any cycle; the new direction takes effect at the next edge, with no extra latency.
- Latency: one cycle from ena/load to the new cnt.
- Arithmetic is carried out in WIDTH bits; no intermediate value exceeds MODULUS-1, so there is no overflow for any legal MODULUS.
- Reset mid-count: reset overrides a simultaneous load or ena, and carry is low while res is high.
- MODULUS == 2**WIDTH: the wrap comparisons still apply; the counter never relies on natural binary overflow.

Optional Feature:
- Macro: COUNTER_MODN_BCD_EN.
- When defined:
  - Adds outputs bcd_tens[3:0] and bcd_ones[3:0], registered and updated on the same edge as cnt from its next value.
  - They equal next_cnt/10 and next_cnt%10.
  - Reset value is the BCD form of RESET_VAL.
  - Legal only for MODULUS <= 100; elaboration errors otherwise.
- When undefined: these ports and their logic do not exist, and all other behaviour is identical.

Decomposition:
- Package counter_pkg:
  - Direction constants DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
  - Function clog2_min1 returning max(1, $clog2(n)).
  - Constant BCD_MAX_MODULUS = 100.
- One natural sub-module: bcd_split. It is combinational and converts a value of at most 7 bits into tens/ones nibbles by repeated subtraction or a constant-divide. It is instantiated only under COUNTER_MODN_BCD_EN.

Test Plan:
1. MODULUS=6, res=1 for 2 cycles then ena=1, dir=0 for 8 cycles -> cnt 0,1,2,3,4,5,0,1. is_max high only with cnt=5. carry high only in the cycle cnt=5.
2. MODULUS=10, dir=1 from cnt=0, ena=1 -> cnt 9,8,... with carry high while cnt=0. is_min tracks cnt=0 with no lag.
3. MODULUS=24, load=1, load_val=30 -> cnt=23 and is_max=1 next cycle. With load_val=7 and ena=1 in the same cycle -> cnt=7 and carry=0.
4. Cascade of MODULUS=10 into MODULUS=6 (carry->ena), 60 enabled cycles -> upper stage steps once per 10 cycles. Both reach 0 on cycle 60. Upper carry is high exactly once, at cycle 60.
5. Assert res with load=1 and ena=1 mid-count at cnt=4, RESET_VAL=2 -> cnt=2, is_max=0, is_min=0, carry=0.
6. COUNTER_MODN_BCD_EN, MODULUS=60, load_val=47 -> bcd_tens=4 and bcd_ones=7 in the same cycle cnt=47. After 13 enabled cycles -> cnt=0, BCD 0/0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N digit counter.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int BCD_MAX_MODULUS = 100;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_split.sv
// Combinational split of a value 0..99 into BCD tens/ones nibbles.
module bcd_split (
  input  logic [6:0] i_val,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [6:0] w_tens;
  logic [6:0] w_ones;

  assign w_tens = i_val / 7'd10;
  assign w_ones = i_val % 7'd10;
  assign o_tens = w_tens[3:0];
  assign o_ones = w_ones[3:0];

endmodule

// File: rtl/counter_modn.sv
// Modulo-N up/down counter with preset load, registered terminal flags and a
// same-cycle carry for cascading. Define COUNTER_MODN_BCD_EN for BCD outputs.
module counter_modn
  import counter_pkg::*;
#(
  parameter int MODULUS   = 6,
  parameter int WIDTH     = clog2_min1(MODULUS),
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             ena,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             is_max,
  output logic             is_min,
  output logic             carry
`ifdef COUNTER_MODN_BCD_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`endif
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);

  if (MODULUS < 2 || MODULUS > 256) begin : g_bad_mod
    $error("counter_modn: MODULUS out of range 2..256");
  end
  if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
    $error("counter_modn: WIDTH too small for MODULUS");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
    $error("counter_modn: RESET_VAL must be below MODULUS");
  end

  logic [WIDTH-1:0] r_cnt;
  logic             r_is_max;
  logic             r_is_min;
  logic [WIDTH-1:0] w_next;

  // Wraps are explicit compares so MODULUS == 2**WIDTH needs no overflow.
  always_comb begin
    w_next = r_cnt;
    if (load) begin
      w_next = ({1'b0, load_val} < MOD_X) ? load_val : MAX_V;
    end else if (ena) begin
      if (dir == DIR_UP) w_next = (r_cnt == MAX_V) ? '0 : r_cnt + WIDTH'(1);
      else               w_next = (r_cnt == '0)    ? MAX_V : r_cnt - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_cnt    <= RST_V;
      r_is_max <= (RST_V == MAX_V);
      r_is_min <= (RST_V == '0);
    end else begin
      r_cnt    <= w_next;
      r_is_max <= (w_next == MAX_V);
      r_is_min <= (w_next == '0);
    end
  end

  assign cnt    = r_cnt;
  assign is_max = r_is_max;
  assign is_min = r_is_min;
  assign carry  = ena & ~load & ~res &
                  (((dir == DIR_UP) & r_is_max) | ((dir == DIR_DOWN) & r_is_min));

`ifdef COUNTER_MODN_BCD_EN
  localparam logic [3:0] RST_T = 4'(RESET_VAL / 10);
  localparam logic [3:0] RST_O = 4'(RESET_VAL % 10);

  if (MODULUS > BCD_MAX_MODULUS) begin : g_bad_bcd
    $error("counter_modn: BCD outputs need MODULUS <= 100");
  end

  logic [3:0] r_bcd_tens;
  logic [3:0] r_bcd_ones;
  logic [3:0] w_bcd_tens;
  logic [3:0] w_bcd_ones;

  bcd_split u_bcd (
    .i_val  (7'(w_next)),
    .o_tens (w_bcd_tens),
    .o_ones (w_bcd_ones)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      r_bcd_tens <= RST_T;
      r_bcd_ones <= RST_O;
    end else begin
      r_bcd_tens <= w_bcd_tens;
      r_bcd_ones <= w_bcd_ones;
    end
  end

  assign bcd_tens = r_bcd_tens;
  assign bcd_ones = r_bcd_ones;
`endif

endmodule

// File: tb/tb_counter_modn.sv
// Directed-vector bench for counter_modn: several instances, one per scenario.
module tb_counter_modn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // a: mod 6
  logic a_res = 1, a_ena = 0, a_dir = 0, a_load = 0;
  logic [2:0] a_lv = '0, a_cnt;
  logic a_max, a_min, a_carry;
  // b: mod 10
  logic b_res = 1, b_ena = 0, b_dir = 0, b_load = 0;
  logic [3:0] b_lv = '0, b_cnt;
  logic b_max, b_min, b_carry;
  // c: mod 24
  logic c_res = 1, c_ena = 0, c_dir = 0, c_load = 0;
  logic [4:0] c_lv = '0, c_cnt;
  logic c_max, c_min, c_carry;
  // cascade: l (mod 10) -> h (mod 6)
  logic k_res = 1, l_ena = 0, k_dir = 0, k_load = 0;
  logic [3:0] l_lv = '0, l_cnt;
  logic [2:0] h_lv = '0, h_cnt;
  logic l_max, l_min, l_carry, h_max, h_min, h_carry;
  // q: mod 6, RESET_VAL 2
  logic q_res = 1, q_ena = 0, q_dir = 0, q_load = 0;
  logic [2:0] q_lv = '0, q_cnt;
  logic q_max, q_min, q_carry;
`ifdef COUNTER_MODN_BCD_EN
  logic [3:0] a_bt, a_bo, b_bt, b_bo, c_bt, c_bo, l_bt, l_bo, h_bt, h_bo, q_bt, q_bo;
  logic g_res = 1, g_ena = 0, g_dir = 0, g_load = 0;
  logic [5:0] g_lv = '0, g_cnt;
  logic g_max, g_min, g_carry;
  logic [3:0] g_bt, g_bo;
`endif

  counter_modn #(.MODULUS(6)) u_a (
    .clk(clk), .res(a_res), .ena(a_ena), .dir(a_dir), .load(a_load), .load_val(a_lv),
    .cnt(a_cnt), .is_max(a_max), .is_min(a_min), .carry(a_carry)
`ifdef COUNTER_MODN_BCD_EN
    , .bcd_tens(a_bt), .bcd_ones(a_bo)
`endif
  );
  counter_modn #(.MODULUS(10)) u_b (
    .clk(clk), .res(b_res), .ena(b_ena), .dir(b_dir), .load(b_load), .load_val(b_lv),
    .cnt(b_cnt), .is_max(b_max), .is_min(b_min), .carry(b_carry)
`ifdef COUNTER_MODN_BCD_EN
    , .bcd_tens(b_bt), .bcd_ones(b_bo)
`endif
  );
  counter_modn #(.MODULUS(24)) u_c (
    .clk(clk), .res(c_res), .ena(c_ena), .dir(c_dir), .load(c_load), .load_val(c_lv),
    .cnt(c_cnt), .is_max(c_max), .is_min(c_min), .carry(c_carry)
`ifdef COUNTER_MODN_BCD_EN
    , .bcd_tens(c_bt), .bcd_ones(c_bo)
`endif
  );
  counter_modn #(.MODULUS(10)) u_lo (
    .clk(clk), .res(k_res), .ena(l_ena), .dir(k_dir), .load(k_load), .load_val(l_lv),
    .cnt(l_cnt), .is_max(l_max), .is_min(l_min), .carry(l_carry)
`ifdef COUNTER_MODN_BCD_EN
    , .bcd_tens(l_bt), .bcd_ones(l_bo)
`endif
  );
  counter_modn #(.MODULUS(6)) u_hi (
    .clk(clk), .res(k_res), .ena(l_carry), .dir(k_dir), .load(k_load), .load_val(h_lv),
    .cnt(h_cnt), .is_max(h_max), .is_min(h_min), .carry(h_carry)
`ifdef COUNTER_MODN_BCD_EN
    , .bcd_tens(h_bt), .bcd_ones(h_bo)
`endif
  );
  counter_modn #(.MODULUS(6), .RESET_VAL(2)) u_q (
    .clk(clk), .res(q_res), .ena(q_ena), .dir(q_dir), .load(q_load), .load_val(q_lv),
    .cnt(q_cnt), .is_max(q_max), .is_min(q_min), .carry(q_carry)
`ifdef COUNTER_MODN_BCD_EN
    , .bcd_tens(q_bt), .bcd_ones(q_bo)
`endif
  );
`ifdef COUNTER_MODN_BCD_EN
  counter_modn #(.MODULUS(60)) u_g (
    .clk(clk), .res(g_res), .ena(g_ena), .dir(g_dir), .load(g_load), .load_val(g_lv),
    .cnt(g_cnt), .is_max(g_max), .is_min(g_min), .carry(g_carry),
    .bcd_tens(g_bt), .bcd_ones(g_bo)
  );
`endif

  task automatic test_reset();
    a_res = 1; a_ena = 1; a_dir = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (a_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d expected 0", a_cnt); end
    n_cmp++; if (a_min !== 1'b1) begin n_err++; $display("FAIL reset_is_min: got %b expected 1", a_min); end
    n_cmp++; if (a_max !== 1'b0) begin n_err++; $display("FAIL reset_is_max: got %b expected 0", a_max); end
    n_cmp++; if (a_carry !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", a_carry); end
  endtask

  task automatic test_count_up();
    int e;
    a_res = 0; a_ena = 1; a_dir = 0;
    for (int i = 0; i < 8; i++) begin
      e = i % 6;
      #1;
      n_cmp++; if (a_cnt !== 3'(e)) begin n_err++; $display("FAIL up_cnt[%0d]: got %0d expected %0d", i, a_cnt, e); end
      n_cmp++; if (a_max !== (e == 5)) begin n_err++; $display("FAIL up_is_max[%0d]: got %b expected %b", i, a_max, e == 5); end
      n_cmp++; if (a_carry !== (e == 5)) begin n_err++; $display("FAIL up_carry[%0d]: got %b expected %b", i, a_carry, e == 5); end
      @(negedge clk);
    end
    a_ena = 0;
  endtask

  task automatic test_count_down();
    int e;
    b_res = 1; @(posedge clk); @(negedge clk);
    b_res = 0; b_ena = 1; b_dir = 1;
    for (int i = 0; i < 12; i++) begin
      e = (10 - (i % 10)) % 10;
      #1;
      n_cmp++; if (b_cnt !== 4'(e)) begin n_err++; $display("FAIL down_cnt[%0d]: got %0d expected %0d", i, b_cnt, e); end
      n_cmp++; if (b_min !== (e == 0)) begin n_err++; $display("FAIL down_is_min[%0d]: got %b expected %b", i, b_min, e == 0); end
      n_cmp++; if (b_carry !== (e == 0)) begin n_err++; $display("FAIL down_carry[%0d]: got %b expected %b", i, b_carry, e == 0); end
      @(negedge clk);
    end
    b_ena = 0;
  endtask

  task automatic test_load();
    c_res = 1; @(posedge clk); @(negedge clk);
    c_res = 0; c_load = 1; c_lv = 5'd30; c_ena = 0; c_dir = 0;
    @(negedge clk); #1;
    n_cmp++; if (c_cnt !== 5'd23) begin n_err++; $display("FAIL load_clamp30_cnt: got %0d expected 23", c_cnt); end
    n_cmp++; if (c_max !== 1'b1) begin n_err++; $display("FAIL load_clamp30_is_max: got %b expected 1", c_max); end
    c_lv = 5'd7; c_ena = 1; #1;
    n_cmp++; if (c_carry !== 1'b0) begin n_err++; $display("FAIL load_carry_forced_low: got %b expected 0", c_carry); end
    @(negedge clk); #1;
    n_cmp++; if (c_cnt !== 5'd7) begin n_err++; $display("FAIL load7_cnt: got %0d expected 7", c_cnt); end
    n_cmp++; if (c_max !== 1'b0) begin n_err++; $display("FAIL load7_is_max: got %b expected 0", c_max); end
    c_load = 0; c_ena = 0;
    @(negedge clk); #1;
    n_cmp++; if (c_cnt !== 5'd7) begin n_err++; $display("FAIL hold_cnt: got %0d expected 7", c_cnt); end
    c_load = 1; c_lv = 5'd24;
    @(negedge clk); #1;
    n_cmp++; if (c_cnt !== 5'd23) begin n_err++; $display("FAIL load_clamp24_cnt: got %0d expected 23", c_cnt); end
    c_lv = 5'd0;
    @(negedge clk); #1;
    n_cmp++; if (c_min !== 1'b1) begin n_err++; $display("FAIL load0_is_min: got %b expected 1", c_min); end
    c_load = 0; c_ena = 1; c_dir = 1; #1;
    n_cmp++; if (c_carry !== 1'b1) begin n_err++; $display("FAIL down_wrap_carry: got %b expected 1", c_carry); end
    @(negedge clk); #1;
    n_cmp++; if (c_cnt !== 5'd23) begin n_err++; $display("FAIL down_wrap_cnt: got %0d expected 23", c_cnt); end
    c_ena = 0;
  endtask

  task automatic test_cascade();
    int n_carry = 0;
    int carry_at = -1;
    int e;
    k_res = 1; @(posedge clk); @(negedge clk);
    k_res = 0; l_ena = 1;
    for (int c = 1; c <= 60; c++) begin
      e = ((c - 1) / 10) % 6;
      #1;
      n_cmp++; if (h_cnt !== 3'(e)) begin n_err++; $display("FAIL cascade_hi_cnt[%0d]: got %0d expected %0d", c, h_cnt, e); end
      if (h_carry === 1'b1) begin n_carry++; carry_at = c; end
      @(negedge clk);
    end
    l_ena = 0; #1;
    n_cmp++; if (l_cnt !== 4'd0) begin n_err++; $display("FAIL cascade_lo_end: got %0d expected 0", l_cnt); end
    n_cmp++; if (h_cnt !== 3'd0) begin n_err++; $display("FAIL cascade_hi_end: got %0d expected 0", h_cnt); end
    n_cmp++; if (n_carry != 1) begin n_err++; $display("FAIL cascade_carry_count: got %0d expected 1", n_carry); end
    n_cmp++; if (carry_at != 60) begin n_err++; $display("FAIL cascade_carry_cycle: got %0d expected 60", carry_at); end
  endtask

  task automatic test_reset_override();
    q_res = 1; @(posedge clk); @(negedge clk); #1;
    n_cmp++; if (q_cnt !== 3'd2) begin n_err++; $display("FAIL rstval_cnt: got %0d expected 2", q_cnt); end
    q_res = 0; q_ena = 1; q_dir = 0;
    repeat (2) @(negedge clk); #1;
    n_cmp++; if (q_cnt !== 3'd4) begin n_err++; $display("FAIL pre_override_cnt: got %0d expected 4", q_cnt); end
    q_res = 1; q_load = 1; q_lv = 3'd5;
    @(negedge clk); #1;
    n_cmp++; if (q_cnt !== 3'd2) begin n_err++; $display("FAIL override_cnt: got %0d expected 2", q_cnt); end
    n_cmp++; if (q_max !== 1'b0) begin n_err++; $display("FAIL override_is_max: got %b expected 0", q_max); end
    n_cmp++; if (q_min !== 1'b0) begin n_err++; $display("FAIL override_is_min: got %b expected 0", q_min); end
    n_cmp++; if (q_carry !== 1'b0) begin n_err++; $display("FAIL override_carry: got %b expected 0", q_carry); end
    q_res = 0; q_ena = 0;
    @(negedge clk); #1;
    n_cmp++; if (q_max !== 1'b1) begin n_err++; $display("FAIL load5_is_max: got %b expected 1", q_max); end
    q_load = 0; q_res = 1; q_ena = 1; #1;
    n_cmp++; if (q_carry !== 1'b0) begin n_err++; $display("FAIL carry_during_res: got %b expected 0", q_carry); end
    q_res = 0; #1;
    n_cmp++; if (q_carry !== 1'b1) begin n_err++; $display("FAIL carry_after_res: got %b expected 1", q_carry); end
    @(negedge clk); #1;
    n_cmp++; if (q_cnt !== 3'd0) begin n_err++; $display("FAIL wrap_after_res: got %0d expected 0", q_cnt); end
    q_ena = 0;
  endtask

`ifdef COUNTER_MODN_BCD_EN
  task automatic test_bcd();
    g_res = 1; @(posedge clk); @(negedge clk);
    g_res = 0; g_load = 1; g_lv = 6'd47;
    @(negedge clk); #1;
    n_cmp++; if (g_cnt !== 6'd47) begin n_err++; $display("FAIL bcd_load_cnt: got %0d expected 47", g_cnt); end
    n_cmp++; if (g_bt !== 4'd4) begin n_err++; $display("FAIL bcd_load_tens: got %0d expected 4", g_bt); end
    n_cmp++; if (g_bo !== 4'd7) begin n_err++; $display("FAIL bcd_load_ones: got %0d expected 7", g_bo); end
    g_load = 0; g_ena = 1;
    repeat (13) @(negedge clk);
    #1;
    n_cmp++; if (g_cnt !== 6'd0) begin n_err++; $display("FAIL bcd_wrap_cnt: got %0d expected 0", g_cnt); end
    n_cmp++; if (g_bt !== 4'd0) begin n_err++; $display("FAIL bcd_wrap_tens: got %0d expected 0", g_bt); end
    n_cmp++; if (g_bo !== 4'd0) begin n_err++; $display("FAIL bcd_wrap_ones: got %0d expected 0", g_bo); end
    g_ena = 0;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_cascade();
    test_reset_override();
`ifdef COUNTER_MODN_BCD_EN
    test_bcd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
